// File: rtl/loader_pkg.sv
// Shared types and helpers for the bridge-to-memory loader path.
package loader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } bridge_word_t;

    // Number of memory beats needed to replay one 32-bit bridge word.
    function automatic int beats_for_width(input int out_width);
        return 32 / out_width;
    endfunction

    // Reverse the four bytes of a word (used by the optional swap path).
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock show-ahead FIFO: the head entry is always visible on pop_data.
// A push while full is accepted when a pop happens on the same edge.
module sync_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bridge_to_mem_serializer.sv
// Buffers 32-bit bridge writes and replays each as 32/OUT_WIDTH narrow beats
// with incrementing byte addresses, honouring mem_ready backpressure.
// Optional: define BRIDGE_SER_BYTE_SWAP_EN to add a per-word swap_bytes input.
module bridge_to_mem_serializer
    import loader_pkg::*;
#(
    parameter int          OUT_WIDTH  = 8,
    parameter logic [31:0] VALID_BITS = 32'hFFFF_FFFF,
    parameter int          FIFO_DEPTH = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          bridge_addr,
    input  logic [31:0]          bridge_wr_data,
    input  logic                 bridge_wr,
`ifdef BRIDGE_SER_BYTE_SWAP_EN
    input  logic                 swap_bytes,
`endif
    output logic [31:0]          mem_address,
    output logic [OUT_WIDTH-1:0] mem_data,
    output logic                 mem_wr,
    input  logic                 mem_ready,
    output logic                 busy,
    output logic                 overflow
);
    localparam int BEATS = beats_for_width(OUT_WIDTH);
    localparam int STEP  = OUT_WIDTH / 8;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SHIFT = (BEATS > 1) ? OUT_WIDTH : 0;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
`ifdef BRIDGE_SER_BYTE_SWAP_EN
    localparam int ENTRY_W = 65;
`else
    localparam int ENTRY_W = 64;
`endif

    ser_state_t         state, state_next;
    bridge_word_t       in_word, head_word;
    logic [ENTRY_W-1:0] fifo_in, fifo_out;
    logic [31:0]        load_data;
    logic [31:0]        shreg;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full, fifo_empty;
    logic               valid_addr, push_req;
    logic               pop, load, shift;

    assign in_word.addr = bridge_addr;
    assign in_word.data = bridge_wr_data;

`ifdef BRIDGE_SER_BYTE_SWAP_EN
    // Swap request travels with the word so it applies to what was pushed.
    assign fifo_in   = {swap_bytes, in_word};
    assign head_word = fifo_out[63:0];
    assign load_data = fifo_out[64] ? byte_swap(head_word.data) : head_word.data;
`else
    assign fifo_in   = in_word;
    assign head_word = fifo_out;
    assign load_data = head_word.data;
`endif

    assign valid_addr = ((bridge_addr & ~VALID_BITS) == 32'h0);
    assign push_req   = bridge_wr && valid_addr;

    sync_word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (fifo_in),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register; reset drops mem_wr immediately since mem_wr decodes state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and datapath controls; back-to-back words reload without a bubble.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (mem_ready) begin
                    if (beat_cnt != '0) begin
                        shift = 1'b1;
                    end else if (!fifo_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat datapath: load a new word or advance one lane; otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            mem_address <= '0;
            beat_cnt    <= '0;
        end else if (load) begin
            shreg       <= load_data;
            mem_address <= head_word.addr;
            beat_cnt    <= CNT_W'(BEATS - 1);
        end else if (shift) begin
            shreg       <= MSB_FIRST ? (shreg << SHIFT) : (shreg >> SHIFT);
            mem_address <= mem_address + 32'(STEP);
            beat_cnt    <= beat_cnt - 1'b1;
        end
    end

    // Sticky flag for a valid write lost to a full FIFO with no pop that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               overflow <= 1'b0;
        else if (push_req && fifo_full && !pop)  overflow <= 1'b1;
    end

    generate
        if (MSB_FIRST) begin : g_msb
            assign mem_data = shreg[31 -: OUT_WIDTH];
        end else begin : g_lsb
            assign mem_data = shreg[OUT_WIDTH-1:0];
        end
    endgenerate

    assign mem_wr = (state == SEND);
    assign busy   = (fifo_count != '0) || (state == SEND);

endmodule

// File: tb/tb_bridge_to_mem_serializer.sv
// Self-checking bench: three serializer instances (8-bit MSB-first, 16-bit
// LSB-first, 8-bit with a narrow address mask) against a beat-queue model.
module tb_bridge_to_mem_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: OUT_WIDTH=8, MSB first, full address range
    logic [31:0] a_addr, a_wdata, a_maddr;
    logic        a_wr, a_ready, a_mwr, a_busy, a_ovf;
    logic [7:0]  a_mdata;
    // Instance B: OUT_WIDTH=16, LSB first
    logic [31:0] b_addr, b_wdata, b_maddr;
    logic        b_wr, b_ready, b_mwr, b_busy, b_ovf;
    logic [15:0] b_mdata;
    // Instance C: OUT_WIDTH=8, VALID_BITS=0x0000FFFF
    logic [31:0] c_addr, c_wdata, c_maddr;
    logic        c_wr, c_ready, c_mwr, c_busy, c_ovf;
    logic [7:0]  c_mdata;

    bridge_to_mem_serializer #(.OUT_WIDTH(8), .VALID_BITS(32'hFFFF_FFFF),
        .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(rst), .bridge_addr(a_addr), .bridge_wr_data(a_wdata),
        .bridge_wr(a_wr),
`ifdef BRIDGE_SER_BYTE_SWAP_EN
        .swap_bytes(1'b0),
`endif
        .mem_address(a_maddr), .mem_data(a_mdata), .mem_wr(a_mwr),
        .mem_ready(a_ready), .busy(a_busy), .overflow(a_ovf));

    bridge_to_mem_serializer #(.OUT_WIDTH(16), .VALID_BITS(32'hFFFF_FFFF),
        .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(rst), .bridge_addr(b_addr), .bridge_wr_data(b_wdata),
        .bridge_wr(b_wr),
`ifdef BRIDGE_SER_BYTE_SWAP_EN
        .swap_bytes(1'b0),
`endif
        .mem_address(b_maddr), .mem_data(b_mdata), .mem_wr(b_mwr),
        .mem_ready(b_ready), .busy(b_busy), .overflow(b_ovf));

    bridge_to_mem_serializer #(.OUT_WIDTH(8), .VALID_BITS(32'h0000_FFFF),
        .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .reset(rst), .bridge_addr(c_addr), .bridge_wr_data(c_wdata),
        .bridge_wr(c_wr),
`ifdef BRIDGE_SER_BYTE_SWAP_EN
        .swap_bytes(1'b0),
`endif
        .mem_address(c_maddr), .mem_data(c_mdata), .mem_wr(c_mwr),
        .mem_ready(c_ready), .busy(c_busy), .overflow(c_ovf));

    // Reference model for A: every accepted word expands into 4 byte beats.
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } beat_t;
    beat_t exp_a[$];

    task automatic model_word_a(input logic [31:0] addr, input logic [31:0] data);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.addr = addr + 32'(i);
            b.data = 8'((data >> (8 * (3 - i))) & 32'hFF);
            exp_a.push_back(b);
        end
    endtask

    // Beat monitor for A: a beat is handed over when mem_wr && mem_ready at the
    // upcoming edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && a_mwr && a_ready) begin
            n_cmp++;
            if (exp_a.size() == 0) begin
                n_bad++;
                $display("FAIL a_unexpected_beat addr=%h data=%h", a_maddr, a_mdata);
            end else begin
                e = exp_a.pop_front();
                if (a_maddr !== e.addr || a_mdata !== e.data) begin
                    n_bad++;
                    $display("FAIL a_beat got=(%h,%h) exp=(%h,%h)",
                             a_maddr, a_mdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a(input int budget);
        for (int k = 0; k < budget && (exp_a.size() != 0 || a_busy); k++) @(negedge clk);
        n_cmp++;
        if (exp_a.size() != 0 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL a_drain left=%0d busy=%b exp=0,0", exp_a.size(), a_busy);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_wr = 0; a_addr = 0; a_wdata = 0; a_ready = 1;
        b_wr = 0; b_addr = 0; b_wdata = 0; b_ready = 1;
        c_wr = 0; c_addr = 0; c_wdata = 0; c_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_mwr, a_busy, a_ovf, b_mwr, b_busy, c_mwr} !== 6'b0 ||
            a_maddr !== 32'h0 || a_mdata !== 8'h0 || b_mdata !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_state wr=%b busy=%b ovf=%b addr=%h data=%h exp all 0",
                     a_mwr, a_busy, a_ovf, a_maddr, a_mdata);
        end
        tick();
    endtask

    task automatic test_basic_msb();
        a_ready = 1;
        a_addr = 32'h100; a_wdata = 32'hA1B2C3D4; a_wr = 1;
        model_word_a(32'h100, 32'hA1B2C3D4);
        tick();                       // edge E sampled the write
        a_wr = 0;
        @(negedge clk);
        n_cmp++;
        if (a_mwr !== 1'b0 || a_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_after_E wr=%b busy=%b exp wr=0 busy=1", a_mwr, a_busy);
        end
        @(negedge clk);               // after E+1
        n_cmp++;
        if (a_mwr !== 1'b1 || a_maddr !== 32'h100 || a_mdata !== 8'hA1) begin
            n_bad++;
            $display("FAIL basic_E1 wr=%b addr=%h data=%h exp 1,100,a1", a_mwr, a_maddr, a_mdata);
        end
        drain_a(40);
    endtask

    task automatic test_overflow();
        int run, total;
        logic seen_gap;
        logic [31:0] d;
        a_ready = 0;
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            a_addr = 32'h1000 + 32'(16 * k); a_wdata = d; a_wr = 1;
            if (k < 5) model_word_a(a_addr, d);
            tick();
        end
        a_wr = 0;
        @(negedge clk);
        n_cmp++;
        if (a_ovf !== 1'b1 || a_mwr !== 1'b1 || a_maddr !== 32'h1000) begin
            n_bad++;
            $display("FAIL ovf_set ovf=%b wr=%b addr=%h exp 1,1,1000", a_ovf, a_mwr, a_maddr);
        end
        tick();
        a_ready = 1;
        run = 0; total = 0; seen_gap = 0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (a_mwr) begin
                total++;
                if (!seen_gap) run++;
            end else begin
                seen_gap = 1;
            end
        end
        n_cmp++;
        if (run != 20 || total != 20) begin
            n_bad++;
            $display("FAIL ovf_stream run=%0d total=%0d exp 20,20", run, total);
        end
        n_cmp++;
        if (a_ovf !== 1'b1 || exp_a.size() != 0) begin
            n_bad++;
            $display("FAIL ovf_sticky ovf=%b left=%0d exp 1,0", a_ovf, exp_a.size());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        a_ready = 1;
        for (int k = 0; k < 3; k++) begin
            d = $urandom;
            a_addr = 32'h200 + 32'(4 * k); a_wdata = d; a_wr = 1;
            model_word_a(a_addr, d);
            tick();
        end
        a_wr = 0;                     // word 0 now on beat 2, two words queued
        n_cmp++;
        if (a_mwr !== 1'b1 || a_maddr !== 32'h201) begin
            n_bad++;
            $display("FAIL rstmid_pre wr=%b addr=%h exp 1,201", a_mwr, a_maddr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (a_mwr !== 1'b0 || a_busy !== 1'b0 || a_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_async wr=%b busy=%b ovf=%b exp 0,0,0", a_mwr, a_busy, a_ovf);
        end
        exp_a.delete();
        tick();
        rst = 1'b0;
        tick();
        d = $urandom;
        a_addr = 32'h0; a_wdata = d; a_wr = 1;
        model_word_a(32'h0, d);
        tick();
        a_wr = 0;
        drain_a(40);
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        a_ready = 1;
        d = $urandom;
        a_addr = 32'hFFFF_FFFE; a_wdata = d; a_wr = 1;
        model_word_a(32'hFFFF_FFFE, d);
        tick();
        a_wr = 0;
        drain_a(40);
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            a_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && ((exp_a.size() + 3) / 4) < 4) begin
                a_addr = $urandom; a_wdata = $urandom; a_wr = 1;
                model_word_a(a_addr, a_wdata);
            end else begin
                a_wr = 0;
            end
            tick();
        end
        a_wr = 0;
        a_ready = 1;
        drain_a(200);
        n_cmp++;
        if (a_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL random_ovf ovf=%b exp 0", a_ovf);
        end
    endtask

    task automatic test_valid_mask();
        logic any_act;
        c_ready = 1;
        c_addr = 32'h0001_0000; c_wdata = 32'hCAFEF00D; c_wr = 1;
        tick();
        c_wr = 0;
        any_act = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (c_mwr || c_busy) any_act = 1;
        end
        n_cmp++;
        if (any_act !== 1'b0 || c_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL mask_ignore act=%b ovf=%b exp 0,0", any_act, c_ovf);
        end
        tick();
        c_addr = 32'h0000_1234; c_wdata = 32'hDEADBEEF; c_wr = 1;
        tick();
        c_wr = 0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (c_mwr !== 1'b1 || c_maddr !== 32'h1234 || c_mdata !== 8'hDE) begin
            n_bad++;
            $display("FAIL mask_valid wr=%b addr=%h data=%h exp 1,1234,de", c_mwr, c_maddr, c_mdata);
        end
        repeat (6) tick();
    endtask

    task automatic test_stall_lsb();
        logic        rdy_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        wr_exp  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ad_exp  [5] = '{32'h20, 32'h20, 32'h20, 32'h22, 32'h22};
        logic [15:0] dt_exp  [5] = '{16'h3344, 16'h3344, 16'h3344, 16'h1122, 16'h1122};
        b_ready = 1;
        b_addr = 32'h20; b_wdata = 32'h11223344; b_wr = 1;
        tick();
        b_wr = 0;
        b_ready = 0;
        tick();                       // now after E+1: first beat presented
        for (int k = 0; k < 5; k++) begin
            b_ready = rdy_seq[k];
            @(negedge clk);
            n_cmp++;
            if (b_mwr !== wr_exp[k] || (wr_exp[k] &&
                (b_maddr !== ad_exp[k] || b_mdata !== dt_exp[k]))) begin
                n_bad++;
                $display("FAIL stall_lsb[%0d] got=(%b,%h,%h) exp=(%b,%h,%h)", k,
                         b_mwr, b_maddr, b_mdata, wr_exp[k], ad_exp[k], dt_exp[k]);
            end
            tick();
        end
        n_cmp++;
        if (b_busy !== 1'b0 || b_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_lsb_idle busy=%b ovf=%b exp 0,0", b_busy, b_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic_msb();
        test_overflow();
        test_reset_mid();
        test_wrap();
        test_random();
        test_valid_mask();
        test_stall_lsb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a wait somehow never returns.
    initial begin
        #200000;
        $display("FAIL global_timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
